reg_scoreboard: RTL and testbench

Per-register pending-write scoreboard for the dual-issue RV64 pipeline. It counts the writes to each architectural register that have been issued but not yet written back. It reports busy and saturation status to the issue controller so that hazards on in-flight results can be stalled. It sits beside the ID-stage regfile/forward logic: issue events arrive from ID, retire events come from the WB write ports.

---
 rtl/reg_scoreboard.sv | 122 ++++++++++++
 tb/tb_reg_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: counts issued-but-not-written-back
// results per architectural register and answers busy/saturation queries.
module reg_scoreboard #(
  parameter int REG_NUM   = 32,
  parameter int ISSUE_NUM = 2,
  parameter int CNT_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [ISSUE_NUM-1:0]      issue_en,
  input  logic [ISSUE_NUM-1:0]      issue_rd_en,
  input  logic [ISSUE_NUM-1:0][4:0] issue_rd,
  input  logic [ISSUE_NUM-1:0][4:0] issue_rs1,
  input  logic [ISSUE_NUM-1:0][4:0] issue_rs2,
  input  logic [ISSUE_NUM-1:0]      wb_en,
  input  logic [ISSUE_NUM-1:0][4:0] wb_rd,
  output logic [ISSUE_NUM-1:0]      rs1_busy,
  output logic [ISSUE_NUM-1:0]      rs2_busy,
  output logic [ISSUE_NUM-1:0]      rd_sat,
  output logic                      idle,
  output logic                      ovf_err,
  output logic                      udf_err
);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]        cnt_q [1:REG_NUM-1];
  logic [CNT_W-1:0]        cnt_d [1:REG_NUM-1];
  logic [CNT_W-1:0]        cnt_view_s [0:31];
  logic                    ovf_err_q, ovf_err_d;
  logic                    udf_err_q, udf_err_d;
  logic signed [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0]        ahead_s;

  // Address-indexed view of the counters; x0 and unimplemented registers read 0.
  always_comb begin
    for (int a = 0; a < 32; a++) begin
      cnt_view_s[a] = CNT_ZERO;
    end
    for (int a = 1; a < REG_NUM; a++) begin
      cnt_view_s[a] = cnt_q[a];
    end
  end

  // Next counter values: add issues, subtract writebacks, clamp and flag errors.
  always_comb begin
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    sum_s     = {SUM_W{1'b0}};
    for (int r = 1; r < REG_NUM; r++) begin
      sum_s = $signed({2'b00, cnt_q[r]});
      for (int i = 0; i < ISSUE_NUM; i++) begin
        sum_s = sum_s + $signed({{(SUM_W-1){1'b0}},
                  issue_en[i] & issue_rd_en[i] & (issue_rd[i] == 5'(r))});
        sum_s = sum_s - $signed({{(SUM_W-1){1'b0}}, wb_en[i] & (wb_rd[i] == 5'(r))});
      end
      if (flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (sum_s[SUM_W-1]) begin
        cnt_d[r]  = CNT_ZERO;
        udf_err_d = 1'b1;
      end else if (sum_s > $signed({2'b00, CNT_MAX})) begin
        cnt_d[r]  = CNT_MAX;
        ovf_err_d = 1'b1;
      end else begin
        cnt_d[r] = sum_s[CNT_W-1:0];
      end
    end
  end

  // Busy queries read registered state only; no same-cycle bypass.
  always_comb begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      rs1_busy[i] = (issue_rs1[i] != 5'd0) && (cnt_view_s[issue_rs1[i]] != CNT_ZERO);
      rs2_busy[i] = (issue_rs2[i] != 5'd0) && (cnt_view_s[issue_rs2[i]] != CNT_ZERO);
    end
  end

  // A slot saturates when its rd count plus older same-rd issues in the bundle reaches max.
  always_comb begin
    ahead_s = {SUM_W{1'b0}};
    for (int i = 0; i < ISSUE_NUM; i++) begin
      ahead_s = {2'b00, cnt_view_s[issue_rd[i]]};
      for (int j = 0; j < i; j++) begin
        ahead_s = ahead_s + {{(SUM_W-1){1'b0}},
                  issue_en[j] & issue_rd_en[j] & (issue_rd[j] == issue_rd[i])};
      end
      rd_sat[i] = issue_rd_en[i] && (issue_rd[i] != 5'd0) && (ahead_s >= {2'b00, CNT_MAX});
    end
  end

  // Idle when no register has an outstanding write.
  always_comb begin
    idle = 1'b1;
    for (int r = 1; r < REG_NUM; r++) begin
      idle = idle & (cnt_q[r] == CNT_ZERO);
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < REG_NUM; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign udf_err = udf_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized + directed scoreboard bench for reg_scoreboard against an
// integer-array reference model of the pending-write counts.
module tb_reg_scoreboard;
  localparam int MAXC = 3;

  logic            clk, rst, flush;
  logic [1:0]      issue_en, issue_rd_en, wb_en;
  logic [1:0][4:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic [1:0]      rs1_busy, rs2_busy, rd_sat;
  logic            idle, ovf_err, udf_err;

  typedef struct packed {
    logic [1:0] b1;
    logic [1:0] b2;
    logic [1:0] sat;
    logic       idl;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_cnt[32];
  bit   m_ovf, m_udf;

  reg_scoreboard #(.REG_NUM(32), .ISSUE_NUM(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_en(issue_en), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_sat(rd_sat),
    .idle(idle), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, ex);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs1_busy", rs1_busy, e.b1);
        chk("rs2_busy", rs2_busy, e.b2);
        chk("rd_sat", rd_sat, e.sat);
        chk("idle", {1'b0, idle}, {1'b0, e.idl});
        chk("ovf_err", {1'b0, ovf_err}, {1'b0, e.ovf});
        chk("udf_err", {1'b0, udf_err}, {1'b0, e.udf});
      end
    end
  end

  function automatic exp_t model_expect();
    exp_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      e.b1[i] = (issue_rs1[i] != 0) && (m_cnt[issue_rs1[i]] != 0);
      e.b2[i] = (issue_rs2[i] != 0) && (m_cnt[issue_rs2[i]] != 0);
    end
    e.sat[0] = issue_rd_en[0] && issue_rd[0] != 0 && m_cnt[issue_rd[0]] == MAXC;
    e.sat[1] = issue_rd_en[1] && issue_rd[1] != 0 &&
               (m_cnt[issue_rd[1]] == MAXC ||
                (m_cnt[issue_rd[1]] == MAXC - 1 && issue_en[0] && issue_rd_en[0] &&
                 issue_rd[0] == issue_rd[1]));
    e.idl = 1'b1;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) e.idl = 1'b0;
    e.ovf = m_ovf;
    e.udf = m_udf;
    return e;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_update();
    int n;
    if (rst) model_reset();
    else if (flush) for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    else begin
      for (int r = 1; r < 32; r++) begin
        n = m_cnt[r];
        for (int i = 0; i < 2; i++) begin
          if (issue_en[i] && issue_rd_en[i] && issue_rd[i] == r) n++;
          if (wb_en[i] && wb_rd[i] == r) n--;
        end
        if (n < 0) begin m_cnt[r] = 0; m_udf = 1'b1; end
        else if (n > MAXC) begin m_cnt[r] = MAXC; m_ovf = 1'b1; end
        else m_cnt[r] = n;
      end
    end
  endtask

  // One cycle: inputs already set at posedge+1; queue expectation, advance model.
  task automatic tick();
    if (rst) model_reset();
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    flush = 1'b0; issue_en = '0; issue_rd_en = '0; issue_rd = '0;
    issue_rs1 = '0; issue_rs2 = '0; wb_en = '0; wb_rd = '0;
  endtask

  task automatic iss(input int s, input logic [4:0] rd);
    issue_en[s] = 1'b1; issue_rd_en[s] = 1'b1; issue_rd[s] = rd;
  endtask

  task automatic wb(input int p, input logic [4:0] rd);
    wb_en[p] = 1'b1; wb_rd[p] = rd;
  endtask

  task automatic query(input logic [4:0] a, input logic [4:0] b);
    issue_rs1 = {b, a}; issue_rs2 = {a, b};
  endtask

  task automatic rand_step();
    exp_t e;
    idle_in();
    for (int i = 0; i < 2; i++) begin
      issue_en[i]    = 1'($urandom_range(0, 1));
      issue_rd_en[i] = ($urandom_range(0, 3) != 0);
      issue_rd[i]    = 5'($urandom_range(0, 7));
      issue_rs1[i]   = 5'($urandom_range(0, 7));
      issue_rs2[i]   = 5'($urandom_range(0, 7));
    end
    e = model_expect();
    if (e.sat[0]) issue_en[0] = 1'b0;
    e = model_expect();
    if (e.sat[1]) issue_en[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 8; t++) begin
          int r;
          int avail;
          r = $urandom_range(1, 7);
          avail = m_cnt[r] - ((p == 1 && wb_en[0] && wb_rd[0] == r) ? 1 : 0);
          if (avail > 0) begin
            wb(p, 5'(r));
            break;
          end
        end
      end
    end
    flush = ($urandom_range(0, 24) == 0);
    tick();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    query(5'd5, 5'd0); tick();
    rst = 1'b0;

    // Single hazard on x5
    idle_in(); iss(0, 5'd5); query(5'd5, 5'd5); tick();
    idle_in(); query(5'd5, 5'd0); tick();
    tick();
    idle_in(); wb(1, 5'd5); query(5'd5, 5'd5); tick();
    idle_in(); query(5'd5, 5'd5); tick();

    // Dual issue to x7, staged writebacks, issue+WB net-out
    idle_in(); iss(0, 5'd7); iss(1, 5'd7); query(5'd7, 5'd7); tick();
    idle_in(); wb(0, 5'd7); query(5'd7, 5'd7); tick();
    idle_in(); query(5'd7, 5'd0); tick();
    idle_in(); iss(0, 5'd7); wb(1, 5'd7); query(5'd7, 5'd7); tick();
    idle_in(); query(5'd7, 5'd7); tick();
    idle_in(); wb(0, 5'd7); query(5'd7, 5'd7); tick();
    idle_in(); query(5'd7, 5'd7); tick();

    // x0 is never tracked
    idle_in(); iss(0, 5'd0); iss(1, 5'd0); wb(0, 5'd0); wb(1, 5'd0); query(5'd0, 5'd0); tick();
    idle_in(); query(5'd0, 5'd0); tick();

    // Mid-run async reset with x5 pending twice and other activity live
    idle_in(); iss(0, 5'd5); iss(1, 5'd5); tick();
    idle_in(); query(5'd5, 5'd5); tick();
    rst = 1'b1; iss(0, 5'd5); wb(1, 5'd5); flush = 1'b1; query(5'd5, 5'd6); tick();
    rst = 1'b0;
    idle_in(); query(5'd5, 5'd5); tick();

    // Constrained random legal traffic
    for (int k = 0; k < 400; k++) rand_step();
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;

    // Saturation on x9
    idle_in(); iss(0, 5'd9); iss(1, 5'd9); tick();
    idle_in(); iss(0, 5'd9); issue_rd_en[1] = 1'b1; issue_rd[1] = 5'd9; query(5'd9, 5'd9); tick();
    idle_in(); iss(0, 5'd9); query(5'd9, 5'd0); tick();
    idle_in(); issue_rd_en = 2'b11; issue_rd = {5'd9, 5'd9}; query(5'd9, 5'd9); tick();
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;

    // Flush, then underflow from a squashed-too-late writeback
    idle_in(); iss(0, 5'd3); iss(1, 5'd4); query(5'd3, 5'd4); tick();
    idle_in(); iss(0, 5'd4); query(5'd3, 5'd4); tick();
    idle_in(); flush = 1'b1; iss(0, 5'd6); query(5'd3, 5'd4); tick();
    idle_in(); query(5'd3, 5'd6); tick();
    idle_in(); wb(0, 5'd3); query(5'd3, 5'd4); tick();
    idle_in(); query(5'd3, 5'd0); tick();
    idle_in(); flush = 1'b1; tick();
    idle_in(); query(5'd4, 5'd3); tick();
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    idle_in(); tick();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
